// File: rtl/signed_add_arbiter.sv
// rtl/signed_add_arbiter.sv - round-robin shared signed adder with overflow flag
// One registered result stage with backpressure; saturating overflow counter.
module signed_add_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [IDW-1:0]     res_id,
  output logic [W-1:0]       res_sum,
  output logic               res_overflow,
  output logic [7:0]         ovf_count
);

  logic           res_valid_q, res_valid_d;
  logic [IDW-1:0] res_id_q, res_id_d;
  logic [W-1:0]   res_sum_q, res_sum_d;
  logic           res_ovf_q, res_ovf_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [7:0]     ovf_cnt_q, ovf_cnt_d;

  logic           accept;
  logic           grant_any;
  logic [IDW-1:0] grant_idx;
  logic [W-1:0]   a_g, b_g, sum_g;
  logic           ovf_g;
  logic           xfer;

  assign accept = !res_valid_q || res_ready;

  // Search order starts at ptr and wraps; operands do not feed this path.
  always_comb begin
    int cand_int;
    logic [IDW-1:0] cand;
    grant_any = 1'b0;
    grant_idx = '0;
    cand_int  = 0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_int = int'(ptr_q) + k;
      if (cand_int >= N_REQ) cand_int = cand_int - N_REQ;
      cand = IDW'(cand_int);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign xfer = grant_any && accept && rst;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (xfer && grant_idx == IDW'(i)) req_ready[i] = 1'b1;
    end
  end

  always_comb begin
    a_g = '0;
    b_g = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        a_g = req_a[i*W +: W];
        b_g = req_b[i*W +: W];
      end
    end
  end

  assign sum_g = a_g + b_g;
  assign ovf_g = (a_g[W-1] == b_g[W-1]) && (sum_g[W-1] != a_g[W-1]);

  always_comb begin
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_sum_d   = res_sum_q;
    res_ovf_d   = res_ovf_q;
    ptr_d       = ptr_q;
    ovf_cnt_d   = ovf_cnt_q;
    if (xfer) begin
      res_valid_d = 1'b1;
      res_id_d    = grant_idx;
      res_sum_d   = sum_g;
      res_ovf_d   = ovf_g;
      ptr_d       = (grant_idx == IDW'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
      if (ovf_g && ovf_cnt_q != 8'hFF) ovf_cnt_d = ovf_cnt_q + 8'd1;
    end else if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_sum_q   <= '0;
      res_ovf_q   <= 1'b0;
      ptr_q       <= '0;
      ovf_cnt_q   <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_sum_q   <= res_sum_d;
      res_ovf_q   <= res_ovf_d;
      ptr_q       <= ptr_d;
      ovf_cnt_q   <= ovf_cnt_d;
    end
  end

  assign res_valid    = res_valid_q;
  assign res_id       = res_id_q;
  assign res_sum      = res_sum_q;
  assign res_overflow = res_ovf_q;
  assign ovf_count    = ovf_cnt_q;

endmodule

// File: doc/signed_add_arbiter.md
# signed_add_arbiter

Shares one W-bit two's-complement adder with overflow detection among N_REQ requesters. It uses round-robin arbitration, a valid/ready handshake on every requester port and one registered result stage with backpressure. It sits between requester datapaths and the downstream consumer of sums. It also keeps a saturating count of overflowed results for status readout.

## Interface
- N_REQ, default 4: number of requesters, 2..8.
- W, default 4: operand and sum width in bits, two's complement.
- IDW, default $clog2(N_REQ): width of the requester index.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset: state resets on a rising clk edge while rst == 0.
- req_valid  input  N_REQ  bit i: requester i presents operands.
- req_a  input  N_REQ*W  operand a of requester i at bits [i*W +: W].
- req_b  input  N_REQ*W  operand b of requester i at bits [i*W +: W].
- req_ready  output  N_REQ  one-hot or zero; bit i: requester i's operands are taken this cycle.
- res_valid  output  1  result register holds an unconsumed result.
- res_ready  input  1  consumer accepts the result this cycle.
- res_id  output  IDW  index of the requester that produced the result.
- res_sum  output  W  sum (a + b) mod 2^W.
- res_overflow  output  1  signed overflow of that sum.
- ovf_count  output  8  saturating count of results with overflow = 1.

## Operation
- accept = !res_valid || res_ready. The result register can load this cycle when accept is 1.
- Arbitration is combinational over req_valid and a round-robin pointer ptr (IDW bits).
  - The grant goes to the first i with req_valid[i] = 1, searching ptr, ptr+1, … mod N_REQ.
  - req_ready[g] = accept for the granted index g; all other bits are 0.
  - req_ready is 0 when no request is present or when rst == 0.
- Transfer: req_valid[g] && req_ready[g]. On a transfer edge:
  - res_sum <= a_g + b_g, truncated to W bits.
  - res_overflow <= (a_g[W-1] == b_g[W-1]) && (sum[W-1] != a_g[W-1]).
  - res_id <= g, res_valid <= 1.
  - ptr <= (g + 1) mod N_REQ.
  - ovf_count increments if overflow is 1; it holds at 255 once reached.
- If res_valid && res_ready and there is no transfer, res_valid <= 0 and the other result fields hold.
- If res_valid && !res_ready, res_sum, res_overflow and res_id are held stable.
- Requesters hold req_valid and their operands until req_ready. req_ready never depends on res_ready through any path other than accept.
- ptr does not move without a transfer.
- Reset values:
  - res_valid = 0, res_sum = 0, res_overflow = 0, res_id = 0.
  - ptr = 0, ovf_count = 0.
- Reset mid-operation discards any pending result; nothing is replayed.

## Timing
- Latency: a transfer in cycle t gives res_valid = 1 with the result in cycle t+1.
- Throughput: one result per cycle when res_ready is held at 1.
- Simultaneous consume and load: when res_valid && res_ready and a transfer occur in the same cycle, the new result replaces the old and res_valid stays 1.
- Fairness: with all N_REQ requesting continuously and res_ready = 1, grants cycle 0,1,…,N_REQ-1,0. No requester waits more than N_REQ-1 transfers.
- The combinational path is req_valid/res_ready → req_ready. It contains no loop, because req_ready does not depend on req_a or req_b.
- The first edge with rst == 1 after reset may already perform a transfer.

## Test plan
- Overflow set (W=4), requester 0 only, res_ready = 1:
  - 7 + 1 → res_sum 4'b1000, overflow 1.
  - -8 + -1 → 4'b0111, overflow 1.
  - res_id 0 in both cases, each result one cycle after its transfer.
- No overflow: 3 + -5 → 4'b1110 (-2), overflow 0; -4 + -4 → 4'b1000, overflow 0; ovf_count unchanged.
- Round robin: all four req_valid held, res_ready = 1 → res_id sequence 0,1,2,3,0,1 on consecutive cycles, and exactly one req_ready bit high per cycle.
- Backpressure:
  - Hold res_ready = 0 for 3 cycles with result 7+1 pending → result fields stable, req_ready all 0.
  - Release res_ready → the next requester is granted in the same cycle.
- Reset mid-stream: assert rst = 0 for one edge while res_valid = 1 and ovf_count = 5 → res_valid 0, ovf_count 0, ptr 0; the first grant after reset goes to the lowest valid index.
- Saturation: 300 overflowing transfers (7+1) → ovf_count reaches 255 and stays at 255.
